// File: rtl/serial_mul_pkg.sv
// -----------------------------------------------------------------------------
// serial_mul_pkg
//   Shared types and helpers for the sequential shift-add multiplier.
//   - state_t      : controller states (IDLE, RUN, DONE)
//   - count_width  : width of the RUN-phase bit counter for a given operand width
// -----------------------------------------------------------------------------
package serial_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Counter must reach width-1; keep at least one bit for degenerate widths.
   function automatic int count_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage : serial_mul_pkg

// File: rtl/serial_mul_datapath.sv
// -----------------------------------------------------------------------------
// serial_mul_datapath
//   Accumulator, shifted multiplicand, shifted multiplier and the single adder
//   of the shift-add multiplier. Sequenced by the controller in
//   serial_multiplier.
//
//   Optional feature: define SERIAL_MUL_SIGNED_EN to treat a/b as two's
//   complement (magnitudes are multiplied, sign is applied when p is loaded).
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   load    in   capture a/b, clear acc (accepting edge)
//   step    in   one add/shift iteration (every RUN cycle)
//   finish  in   last iteration: load p from this cycle's sum
//   a       in   WIDTH      multiplicand
//   b       in   WIDTH      multiplier
//   p       out  2*WIDTH    product, held between completions
// -----------------------------------------------------------------------------
module serial_mul_datapath #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic                 step,
   input  logic                 finish,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic [2*WIDTH-1:0]   p
);

   localparam int PW = 2 * WIDTH;

   logic [PW-1:0]    mcand_q;
   logic [PW-1:0]    acc_q;
   logic [PW-1:0]    p_q;
   logic [WIDTH-1:0] mplier_q;

   logic [WIDTH-1:0] a_cap;
   logic [WIDTH-1:0] b_cap;
   logic [PW-1:0]    acc_sum;
   logic [PW-1:0]    p_final;

   // Sum including this cycle's partial product; feeds both acc and p so the
   // last iteration's add lands in p on the same edge.
   assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SERIAL_MUL_SIGNED_EN
   logic neg_q;

   // -(-2^(W-1)) wraps to 2^(W-1), which is the correct unsigned magnitude.
   assign a_cap   = a[WIDTH-1] ? -a : a;
   assign b_cap   = b[WIDTH-1] ? -b : b;
   assign p_final = neg_q ? -acc_sum : acc_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg_q <= 1'b0;
      end else if (load) begin
         neg_q <= a[WIDTH-1] ^ b[WIDTH-1];
      end
   end
`else
   assign a_cap   = a;
   assign b_cap   = b;
   assign p_final = acc_sum;
`endif

   // NOTE: state registers use non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would chain acc into mcand in one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: operand and accumulator flops are reset too, not only the
         // control path, so an aborted multiply leaves nothing stale behind.
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         p_q      <= '0;
      end else if (load) begin
         mcand_q  <= {{WIDTH{1'b0}}, a_cap};
         mplier_q <= b_cap;
         acc_q    <= '0;
      end else if (step) begin
         acc_q    <= acc_sum;
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         if (finish) begin
            p_q <= p_final;
         end
      end
   end

   assign p = p_q;

endmodule : serial_mul_datapath

// File: rtl/serial_multiplier.sv
// -----------------------------------------------------------------------------
// serial_multiplier
//   Sequential shift-add multiplier, one multiplier bit per clock, LSB first.
//   Start accepted at edge k -> busy in cycles k+1..k+WIDTH -> done pulse in
//   cycle k+WIDTH+1 with p valid. Start in the done cycle is accepted
//   back-to-back; start while busy is ignored.
//
//   Optional feature: SERIAL_MUL_SIGNED_EN (two's-complement operands).
//
// Ports
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   start   in   request a multiply (sampled only while busy=0)
//   a       in   WIDTH      multiplicand, captured on the accepting edge
//   b       in   WIDTH      multiplier, captured on the accepting edge
//   busy    out  high while a multiply is in progress
//   done    out  one-cycle pulse, p valid
//   p       out  2*WIDTH    product, changes only on completion
// -----------------------------------------------------------------------------
module serial_multiplier
   import serial_mul_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   p
);

   localparam int             CW   = count_width(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          load;
   logic          step;
   logic          finish;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case leaves a signal unassigned and infers a latch.
      state_d = state_q;
      count_d = count_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               count_d = '0;
               state_d = RUN;
            end
         end

         RUN: begin
            step    = 1'b1;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            // Back-to-back: a start seen in the done cycle behaves as from IDLE.
            if (start) begin
               load    = 1'b1;
               count_d = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy = (state_q == RUN);
   assign done = (state_q == DONE);

   serial_mul_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (load),
      .step   (step),
      .finish (finish),
      .a      (a),
      .b      (b),
      .p      (p)
   );

endmodule : serial_multiplier

// File: tb/tb_serial_multiplier.sv
// -----------------------------------------------------------------------------
// tb_serial_multiplier
//   Self-checking bench for serial_multiplier at WIDTH=8. Expected products
//   come from a vector table and a small arithmetic model; a scoreboard queue
//   is filled when a start is driven and drained on each done pulse.
//   Honours SERIAL_MUL_SIGNED_EN when the RUN is built with it.
// -----------------------------------------------------------------------------
module tb_serial_multiplier;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic           start;
   logic [W-1:0]   a;
   logic [W-1:0]   b;
   logic           busy;
   logic           done;
   logic [2*W-1:0] p;

   int n_vec  = 0;
   int n_miss = 0;

   logic [2*W-1:0] sb_q[$];

   typedef struct {
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] p_u;
      logic [2*W-1:0] p_s;
   } vec_t;

   vec_t vecs[9];

   serial_multiplier #(
      .WIDTH (W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .p     (p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SERIAL_MUL_SIGNED_EN
      logic signed [2*W-1:0] sx;
      logic signed [2*W-1:0] sy;
      sx = $signed(x);
      sy = $signed(y);
      return sx * sy;
`else
      logic [2*W-1:0] ux;
      logic [2*W-1:0] uy;
      ux = {{W{1'b0}}, x};
      uy = {{W{1'b0}}, y};
      return ux * uy;
`endif
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding product.
   always @(negedge clk) begin : monitor
      logic [2*W-1:0] e;
      if (rst_n && done) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            e = sb_q.pop_front();
            check("scoreboard_p", {48'd0, p}, {48'd0, e});
         end
      end
   end

   // One full multiply with cycle-exact handshake checks.
   task automatic run_mul(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic [2*W-1:0] exp, input string name);
      int busy_cycles;
      @(negedge clk);
      a = ta; b = tb_v; start = 1'b1;
      sb_q.push_back(exp);
      @(negedge clk);
      start = 1'b0;
      a = ~ta; b = ~tb_v;   // operand changes during RUN must not matter
      busy_cycles = 0;
      for (int i = 0; i < W; i++) begin
         if (i > 0) @(negedge clk);
         if (busy && !done) busy_cycles++;
      end
      check({name, "_busy_cycles"}, 64'(busy_cycles), 64'(W));
      @(negedge clk);
      check({name, "_done"}, {62'd0, done, busy}, {62'd0, 2'b10});
      check({name, "_p"}, {48'd0, p}, {48'd0, exp});
      @(negedge clk);
      check({name, "_p_held"}, {47'd0, done, p}, {47'd0, 1'b0, exp});
   endtask

   initial begin : stim
      logic [W-1:0]   ra;
      logic [W-1:0]   rb;
      logic [2*W-1:0] ve;
      int             seen_done;

      vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 16'h0001};
      vecs[1] = '{8'h00, 8'hA5, 16'h0000, 16'h0000};
      vecs[2] = '{8'h0D, 8'h0B, 16'h008F, 16'h008F};
      vecs[3] = '{8'hFD, 8'h05, 16'h04F1, 16'hFFF1};
      vecs[4] = '{8'h80, 8'h80, 16'h4000, 16'h4000};
      vecs[5] = '{8'hFF, 8'h01, 16'h00FF, 16'hFFFF};
      vecs[6] = '{8'h7F, 8'h80, 16'h3F80, 16'hC080};
      vecs[7] = '{8'h01, 8'h00, 16'h0000, 16'h0000};
      vecs[8] = '{8'hFF, 8'h80, 16'h7F80, 16'h0080};

      rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
      repeat (2) @(negedge clk);
      check("reset_state", {46'd0, busy, done, p}, 64'd0);
      rst_n = 1'b1;

      // Table-driven vectors.
      for (int i = 0; i < 9; i++) begin
`ifdef SERIAL_MUL_SIGNED_EN
         ve = vecs[i].p_s;
`else
         ve = vecs[i].p_u;
`endif
         run_mul(vecs[i].a, vecs[i].b, ve, $sformatf("vec%0d", i));
      end

      // start during RUN is ignored; busy is not extended.
      @(negedge clk);
      a = 8'h0D; b = 8'h0B; start = 1'b1;
      sb_q.push_back(16'h008F);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
         if (i > 0) @(negedge clk);
         if (i == 2) begin a = 8'h02; b = 8'h02; start = 1'b1; end
         if (i == 3) start = 1'b0;
         check("ignore_busy", {63'd0, busy}, 64'd1);
      end
      @(negedge clk);
      check("ignore_p", {47'd0, done, p}, {47'd0, 1'b1, 16'h008F});
      @(negedge clk);
      check("ignore_no_extend", {62'd0, busy, done}, 64'd0);

      // Back-to-back: start held through the done cycle.
      @(negedge clk);
      a = 8'h0D; b = 8'h0B; start = 1'b1;
      sb_q.push_back(16'h008F);
      @(negedge clk);
      start = 1'b0;
      for (int i = 1; i < W; i++) @(negedge clk);
      a = 8'h10; b = 8'h10; start = 1'b1;
      sb_q.push_back(16'h0100);
      @(negedge clk);
      check("b2b_first_done", {47'd0, done, p}, {47'd0, 1'b1, 16'h008F});
      @(negedge clk);
      check("b2b_busy_rise", {62'd0, busy, done}, 64'd2);
      start = 1'b0;
      for (int i = 1; i < W; i++) @(negedge clk);
      @(negedge clk);
      check("b2b_second_done", {47'd0, done, p}, {47'd0, 1'b1, 16'h0100});

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      a = 8'hFF; b = 8'hFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("abort_outputs", {46'd0, busy, done, p}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < W + 3; i++) begin
         @(negedge clk);
         if (done || busy) seen_done++;
      end
      check("abort_no_done", 64'(seen_done), 64'd0);
      run_mul(8'h0D, 8'h0B, 16'h008F, "after_abort");

      // A few random operands against the arithmetic model.
      for (int i = 0; i < 6; i++) begin
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         run_mul(ra, rb, model(ra, rb), $sformatf("rand%0d", i));
      end

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_serial_multiplier
